// File: rtl/imuldiv_mul_arbiter_pkg.sv
// Shared definitions for the two-requester multiply arbiter: default widths,
// transaction state encoding and response steering helper.
package imuldiv_mul_arbiter_pkg;

    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_RESULT_W = 64;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = IDLE,
        S_ISSUE = ISSUE,
        S_WAIT  = WAIT,
        S_RESP  = RESP
    } arb_state_e;

    // One-hot response-valid pattern for the requester that owns the transaction.
    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/imuldiv_mul_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. The priority pointer names the requester that
// wins a tie and moves to the other requester whenever a grant is taken.
module imuldiv_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_val,
    input  logic       i_upd,
    output logic [1:0] o_grant
);

    logic r_ptr;

    always_comb begin
        o_grant = 2'b00;
        case (i_val)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_ptr ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
    end

    // Winner N hands priority to requester ~N.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else if (i_upd && (o_grant != 2'b00)) begin
            r_ptr <= ~o_grant[1];
        end
    end

endmodule

// File: rtl/imuldiv_mul_arbiter.sv
// Shares one iterative multiply unit between two val/rdy requesters with
// round-robin arbitration, one outstanding transaction and owner-routed responses.
module imuldiv_mul_arbiter
    import imuldiv_mul_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned RESULT_W = DEF_RESULT_W
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [DATA_W-1:0]   req0_msg_a,
    input  logic [DATA_W-1:0]   req0_msg_b,
    input  logic                req0_val,
    output logic                req0_rdy,
    output logic [RESULT_W-1:0] resp0_msg_result,
    output logic                resp0_val,
    input  logic                resp0_rdy,

    input  logic [DATA_W-1:0]   req1_msg_a,
    input  logic [DATA_W-1:0]   req1_msg_b,
    input  logic                req1_val,
    output logic                req1_rdy,
    output logic [RESULT_W-1:0] resp1_msg_result,
    output logic                resp1_val,
    input  logic                resp1_rdy,

    output logic [DATA_W-1:0]   mulreq_msg_a,
    output logic [DATA_W-1:0]   mulreq_msg_b,
    output logic                mulreq_val,
    input  logic                mulreq_rdy,
    input  logic [RESULT_W-1:0] mulresp_msg_result,
    input  logic                mulresp_val,
    output logic                mulresp_rdy
);

    arb_state_e          r_state;
    logic                r_owner;
    logic [DATA_W-1:0]   r_op_a;
    logic [DATA_W-1:0]   r_op_b;
    logic [RESULT_W-1:0] r_result;
    logic                r_mulreq_val;
    logic                r_mulresp_rdy;
    logic [1:0]          r_resp_val;

    logic                w_idle;
    logic [1:0]          w_req_val;
    logic [1:0]          w_grant;
    logic                w_accept;
    logic                w_owner_rdy;

    assign w_idle      = (r_state == S_IDLE);
    assign w_req_val   = {req1_val, req0_val} & {2{w_idle}};
    assign w_accept    = (w_grant != 2'b00);
    assign w_owner_rdy = r_owner ? resp1_rdy : resp0_rdy;

    // Grants only exist in IDLE because the arbiter never sees val otherwise.
    imuldiv_rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .i_val   (w_req_val),
        .i_upd   (w_accept),
        .o_grant (w_grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_owner       <= 1'b0;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_result      <= '0;
            r_mulreq_val  <= 1'b0;
            r_mulresp_rdy <= 1'b0;
            r_resp_val    <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op_a       <= w_grant[1] ? req1_msg_a : req0_msg_a;
                        r_op_b       <= w_grant[1] ? req1_msg_b : req0_msg_b;
                        r_owner      <= w_grant[1];
                        r_mulreq_val <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mulreq_rdy) begin
                        r_mulreq_val  <= 1'b0;
                        r_mulresp_rdy <= 1'b1;
                        r_state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A single-cycle result pulse is enough: rdy is already high here.
                    if (mulresp_val) begin
                        r_result      <= mulresp_msg_result;
                        r_mulresp_rdy <= 1'b0;
                        r_resp_val    <= owner_onehot(r_owner);
                        r_state       <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (w_owner_rdy) begin
                        r_resp_val <= 2'b00;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_mulreq_val  <= 1'b0;
                    r_mulresp_rdy <= 1'b0;
                    r_resp_val    <= 2'b00;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

    assign req0_rdy         = w_grant[0];
    assign req1_rdy         = w_grant[1];
    assign mulreq_msg_a     = r_op_a;
    assign mulreq_msg_b     = r_op_b;
    assign mulreq_val       = r_mulreq_val;
    assign mulresp_rdy      = r_mulresp_rdy;
    assign resp0_msg_result = r_result;
    assign resp1_msg_result = r_result;
    assign resp0_val        = r_resp_val[0];
    assign resp1_val        = r_resp_val[1];

endmodule

// File: tb/tb_imuldiv_mul_arbiter.sv
// Bench for imuldiv_mul_arbiter: a signed multiply-unit model, a transaction-level
// reference monitor, table vectors, directed corner sequences and random traffic.
module tb_imuldiv_mul_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] req0_msg_a = '0, req0_msg_b = '0, req1_msg_a = '0, req1_msg_b = '0;
    logic        req0_val = 1'b0, req1_val = 1'b0, resp0_rdy = 1'b0, resp1_rdy = 1'b0;
    logic        req0_rdy, req1_rdy, resp0_val, resp1_val;
    logic [63:0] resp0_msg_result, resp1_msg_result;
    logic [31:0] mulreq_msg_a, mulreq_msg_b;
    logic        mulreq_val, mulresp_rdy;
    logic        mulreq_rdy = 1'b0, mulresp_val = 1'b0;
    logic [63:0] mulresp_msg_result = '0;

    always #5 clk = ~clk;

    imuldiv_mul_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_msg_a(req0_msg_a), .req0_msg_b(req0_msg_b), .req0_val(req0_val), .req0_rdy(req0_rdy),
        .resp0_msg_result(resp0_msg_result), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
        .req1_msg_a(req1_msg_a), .req1_msg_b(req1_msg_b), .req1_val(req1_val), .req1_rdy(req1_rdy),
        .resp1_msg_result(resp1_msg_result), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
        .mulreq_msg_a(mulreq_msg_a), .mulreq_msg_b(mulreq_msg_b), .mulreq_val(mulreq_val),
        .mulreq_rdy(mulreq_rdy), .mulresp_msg_result(mulresp_msg_result),
        .mulresp_val(mulresp_val), .mulresp_rdy(mulresp_rdy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return 64'(sa * sb);
    endfunction

    // ---------------- multiply unit model ----------------
    bit          mu_rand = 1'b0, mu_rdy_en = 1'b1, mu_pend = 1'b0;
    int          mu_delay = 1, mu_cnt = 0;
    logic [63:0] mu_res = '0;
    bit          s_rst, s_req_hs, s_resp_hs;
    logic [31:0] s_a, s_b;

    always begin
        @(negedge clk);
        s_rst     = reset;
        s_req_hs  = mulreq_val && mulreq_rdy;
        s_resp_hs = mulresp_val && mulresp_rdy;
        s_a       = mulreq_msg_a;
        s_b       = mulreq_msg_b;
        @(posedge clk);
        #1;
        if (s_rst) begin
            mu_pend     = 1'b0;
            mulresp_val = 1'b0;
        end else begin
            if (s_resp_hs) begin
                mulresp_val = 1'b0;
                mu_pend     = 1'b0;
            end
            if (s_req_hs) begin
                mu_pend = 1'b1;
                mu_res  = smul(s_a, s_b);
                mu_cnt  = mu_rand ? int'($urandom_range(0, 4)) : mu_delay;
            end
            if (mu_pend && !mulresp_val) begin
                if (mu_cnt == 0) begin
                    mulresp_val        = 1'b1;
                    mulresp_msg_result = mu_res;
                end else begin
                    mu_cnt--;
                end
            end
        end
        mulreq_rdy = !mu_pend && mu_rdy_en && (!mu_rand || ($urandom_range(0, 1) == 1));
    end

    // ---------------- transaction-level reference monitor ----------------
    // Tracks the single outstanding transaction by progress flags:
    // accepted -> issued to multiplier -> result captured -> delivered.
    bit          mdl_busy = 0, mdl_owner = 0, mdl_prio = 0, mdl_issued = 0, mdl_capt = 0;
    logic [31:0] mdl_a = '0, mdl_b = '0;
    logic [1:0]  m_acc = '0, m_del = '0;
    logic [63:0] m_del_res = '0;
    int          n_acc = 0, n_del = 0;
    int          grant_log[$];

    always @(negedge clk) begin
        logic [1:0] exp_rdy, exp_resp, own;
        m_acc = 2'b00;
        m_del = 2'b00;
        if (reset) begin
            mdl_busy = 0; mdl_prio = 0; mdl_issued = 0; mdl_capt = 0;
        end else begin
            exp_rdy = 2'b00;
            if (!mdl_busy) begin
                if (req0_val && (!req1_val || !mdl_prio)) exp_rdy = 2'b01;
                else if (req1_val)                        exp_rdy = 2'b10;
            end
            own      = mdl_owner ? 2'b10 : 2'b01;
            exp_resp = (mdl_busy && mdl_capt) ? own : 2'b00;
            check("req_rdy", 64'({req1_rdy, req0_rdy}), 64'(exp_rdy));
            check("resp_val", 64'({resp1_val, resp0_val}), 64'(exp_resp));
            check("mulreq_val", 64'(mulreq_val), 64'(mdl_busy && !mdl_issued));
            check("mulresp_rdy", 64'(mulresp_rdy), 64'(mdl_busy && mdl_issued && !mdl_capt));
            if (mulreq_val)
                check("mulreq_ops", {mulreq_msg_a, mulreq_msg_b}, {mdl_a, mdl_b});
            if ((resp0_val && resp0_rdy) || (resp1_val && resp1_rdy)) begin
                m_del_res = resp1_val ? resp1_msg_result : resp0_msg_result;
                m_del     = {resp1_val, resp0_val};
                check("resp_result", m_del_res, smul(mdl_a, mdl_b));
                mdl_busy = 0; mdl_issued = 0; mdl_capt = 0;
                n_del++;
            end
            if (mulresp_val && mulresp_rdy) mdl_capt = 1;
            if (mulreq_val && mulreq_rdy)   mdl_issued = 1;
            if ((req0_val && req0_rdy) || (req1_val && req1_rdy)) begin
                mdl_owner = req1_rdy;
                mdl_a     = req1_rdy ? req1_msg_a : req0_msg_a;
                mdl_b     = req1_rdy ? req1_msg_b : req0_msg_b;
                mdl_prio  = !req1_rdy;
                mdl_busy  = 1;
                m_acc     = {req1_rdy, req0_rdy};
                grant_log.push_back(req1_rdy ? 1 : 0);
                n_acc++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int delay, input bit rnd);
        tick();
        reset = 1'b1;
        req0_val = 0; req1_val = 0; resp0_rdy = 0; resp1_rdy = 0;
        mu_delay = delay; mu_rand = rnd; mu_rdy_en = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        grant_log.delete();
    endtask

    int          got[2], nacc[2], first_port;
    logic [63:0] res[2];

    task automatic serve_loop(input int want, input int budget);
        got = '{0, 0}; nacc = '{0, 0}; first_port = -1; res = '{64'd0, 64'd0};
        for (int c = 0; c < budget && (got[0] + got[1]) < want; c++) begin
            tick();
            if (m_acc[0]) begin req0_val = 0; nacc[0]++; end
            if (m_acc[1]) begin req1_val = 0; nacc[1]++; end
            for (int n = 0; n < 2; n++) begin
                if (m_del[n]) begin
                    got[n]++;
                    res[n] = m_del_res;
                    if (first_port < 0) first_port = n;
                end
            end
        end
    endtask

    typedef struct {
        bit          v0, v1;
        logic [31:0] a0, b0, a1, b1;
        int          exp_first;
        logic [63:0] exp_r0, exp_r1;
    } vec_t;

    vec_t        vecs[5];
    logic [31:0] ta, tb;
    logic [63:0] texp;
    int          cnt;

    initial begin : main
        vecs[0] = '{1, 0, 32'd3, 32'hFFFF_FFFC, 32'd0, 32'd0, 0, 64'hFFFF_FFFF_FFFF_FFF4, 64'd0};
        vecs[1] = '{1, 1, 32'd5, 32'd7, 32'd6, 32'd9, 0, 64'd35, 64'd54};
        vecs[2] = '{0, 1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'd0, 64'd1};
        vecs[3] = '{1, 0, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 0, 64'h4000_0000_0000_0000, 64'd0};
        vecs[4] = '{1, 1, 32'h7FFF_FFFF, 32'd2, 32'd0, 32'h1234_5678, 0, 64'h0000_0000_FFFF_FFFE, 64'd0};

        for (int i = 0; i < 5; i++) begin
            do_reset(1, 0);
            resp0_rdy = 1; resp1_rdy = 1;
            req0_msg_a = vecs[i].a0; req0_msg_b = vecs[i].b0; req0_val = vecs[i].v0;
            req1_msg_a = vecs[i].a1; req1_msg_b = vecs[i].b1; req1_val = vecs[i].v1;
            serve_loop(int'(vecs[i].v0) + int'(vecs[i].v1), 80);
            check($sformatf("vec%0d_deliv0", i), 64'(got[0]), 64'(vecs[i].v0));
            check($sformatf("vec%0d_deliv1", i), 64'(got[1]), 64'(vecs[i].v1));
            check($sformatf("vec%0d_acc0", i), 64'(nacc[0]), 64'(vecs[i].v0));
            check($sformatf("vec%0d_acc1", i), 64'(nacc[1]), 64'(vecs[i].v1));
            check($sformatf("vec%0d_first", i), 64'(first_port), 64'(vecs[i].exp_first));
            if (vecs[i].v0) check($sformatf("vec%0d_res0", i), res[0], vecs[i].exp_r0);
            if (vecs[i].v1) check($sformatf("vec%0d_res1", i), res[1], vecs[i].exp_r1);
        end

        // Both requesters continuously valid: grants must alternate.
        do_reset(1, 0);
        resp0_rdy = 1; resp1_rdy = 1;
        req0_msg_a = $urandom; req0_msg_b = $urandom; req0_val = 1;
        req1_msg_a = $urandom; req1_msg_b = $urandom; req1_val = 1;
        for (int c = 0; c < 300 && grant_log.size() < 8; c++) begin
            tick();
            if (m_acc[0]) begin req0_msg_a = $urandom; req0_msg_b = $urandom; end
            if (m_acc[1]) begin req1_msg_a = $urandom; req1_msg_b = $urandom; end
        end
        req0_val = 0; req1_val = 0;
        check("alt_count", 64'(grant_log.size() >= 8), 64'd1);
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            check($sformatf("alt_grant%0d", i), 64'(grant_log[i]), 64'(i % 2));

        // Multiplier stalls its ready for three cycles in ISSUE.
        do_reset(1, 0);
        mu_rdy_en = 0;
        resp0_rdy = 1;
        ta = 32'h1234_5678; tb = 32'h9ABC_DEF0;
        req0_msg_a = ta; req0_msg_b = tb; req0_val = 1;
        cnt = 0;
        while (cnt < 10 && !req0_rdy) begin @(negedge clk); cnt++; end
        check("stall_accept", 64'(req0_rdy), 64'd1);
        tick();
        req0_val = 0; req0_msg_a = '0; req0_msg_b = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("stall_val%0d", i), 64'(mulreq_val), 64'd1);
            check($sformatf("stall_ops%0d", i), {mulreq_msg_a, mulreq_msg_b}, {ta, tb});
        end
        mu_rdy_en = 1;
        @(negedge clk);
        check("stall_hs", 64'({mulreq_val, mulreq_rdy}), 64'd3);
        @(negedge clk);
        check("stall_to_wait", 64'({mulreq_val, mulresp_rdy}), 64'd1);
        serve_loop(1, 40);
        check("stall_result", res[0], smul(ta, tb));

        // Owner holds resp ready low; result must be held and no new grant given.
        do_reset(1, 0);
        resp1_rdy = 0; resp0_rdy = 1;
        ta = 32'hFFFF_0000; tb = 32'h0001_0001;
        texp = smul(ta, tb);
        req1_msg_a = ta; req1_msg_b = tb; req1_val = 1;
        for (int c = 0; c < 40 && !resp1_val; c++) begin
            tick();
            if (m_acc[1]) req1_val = 0;
        end
        check("hold_resp_seen", 64'(resp1_val), 64'd1);
        req0_msg_a = 32'd2; req0_msg_b = 32'd3; req0_val = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("hold_val%0d", i), 64'({resp1_val, resp0_val}), 64'd2);
            check($sformatf("hold_res%0d", i), resp1_msg_result, texp);
            check($sformatf("hold_req0_rdy%0d", i), 64'(req0_rdy), 64'd0);
        end
        tick();
        resp1_rdy = 1;
        tick();
        @(negedge clk);
        check("hold_then_idle", 64'({req1_rdy, req0_rdy}), 64'd1);
        serve_loop(1, 40);
        check("hold_next_res", res[0], 64'd6);

        // Reset while waiting on the multiplier drops the transaction.
        do_reset(20, 0);
        resp0_rdy = 1; resp1_rdy = 1;
        req0_msg_a = 32'd11; req0_msg_b = 32'd13; req0_val = 1;
        for (int c = 0; c < 20 && !mulresp_rdy; c++) begin
            tick();
            if (m_acc[0]) req0_val = 0;
        end
        check("rst_reached_wait", 64'(mulresp_rdy), 64'd1);
        reset = 1;
        tick();
        reset = 0;
        mu_delay = 2;
        @(negedge clk);
        check("rst_outputs", 64'({resp1_val, resp0_val, mulreq_val, mulresp_rdy}), 64'd0);
        tick();
        req0_msg_a = 32'd4;          req0_msg_b = 32'hFFFF_FFFF; req0_val = 1;
        req1_msg_a = 32'hFFFF_FFF0;  req1_msg_b = 32'd100;       req1_val = 1;
        @(negedge clk);
        check("rst_ptr_req0_wins", 64'({req1_rdy, req0_rdy}), 64'd1);
        serve_loop(2, 80);
        check("rst_res0", res[0], 64'hFFFF_FFFF_FFFF_FFFC);
        check("rst_res1", res[1], 64'hFFFF_FFFF_FFFF_F9C0);

        // Random traffic against the reference monitor.
        do_reset(0, 1);
        n_acc = 0; n_del = 0;
        for (int c = 0; c < 1500; c++) begin
            tick();
            if (m_acc[0]) req0_val = 0;
            if (m_acc[1]) req1_val = 0;
            if (!req0_val && ($urandom_range(0, 2) == 0)) begin
                req0_val = 1;
                req0_msg_a = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'($urandom);
                req0_msg_b = 32'($urandom);
            end
            if (!req1_val && ($urandom_range(0, 2) == 0)) begin
                req1_val = 1;
                req1_msg_a = 32'($urandom);
                req1_msg_b = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            end
            resp0_rdy = ($urandom_range(0, 1) == 1);
            resp1_rdy = ($urandom_range(0, 1) == 1);
        end
        resp0_rdy = 1; resp1_rdy = 1;
        for (int c = 0; c < 300 && (req0_val || req1_val || n_del != n_acc); c++) begin
            tick();
            if (m_acc[0]) req0_val = 0;
            if (m_acc[1]) req1_val = 0;
        end
        check("rand_drained", 64'(n_del), 64'(n_acc));
        check("rand_progress", 64'(n_acc >= 60), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
